// File: rtl/obi_bus_arbiter.sv
// obi_bus_arbiter: merges the instruction-fetch and LSU OBI request ports onto
// one shared memory port. Round-robin arbitration, address-phase locking, and
// an in-order ID FIFO that routes each response back to its requester.
//
// Handshake: a request transfers on a cycle where mem_req && mem_gnt are both
// high. The source selected for that cycle sees its gnt raised in the same
// cycle. A request that has been presented but not granted is locked, so that
// address and attributes stay stable until the grant. Responses are
// single-cycle mem_rvalid pulses and return in grant order.
module obi_bus_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            instr_req,
    input  logic [31:0]     instr_addr,
    output logic            instr_gnt,
    output logic            instr_rvalid,
    output logic [31:0]     instr_rdata,
    output logic            instr_err,

    input  logic            data_req,
    input  logic            data_we,
    input  logic [3:0]      data_be,
    input  logic [31:0]     data_addr,
    input  logic [31:0]     data_wdata,
    output logic            data_gnt,
    output logic            data_rvalid,
    output logic [31:0]     data_rdata,
    output logic            data_err,

    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    input  logic            mem_err,

    output logic [CntW-1:0] outstanding,
    output logic            resp_underflow
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);

    // Source encoding used by rr_last, lock_src and the ID FIFO.
    localparam logic SrcInstr = 1'b0;
    localparam logic SrcData  = 1'b1;

    logic                      rr_last_q, rr_last_d;
    logic                      locked_q, locked_d;
    logic                      lock_src_q, lock_src_d;
    logic [MaxOutstanding-1:0] id_fifo_q, id_fifo_d;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      underflow_q, underflow_d;

    logic sel;
    logic full;
    logic empty;
    logic grant;
    logic resp_fire;
    logic head_id;

    assign full  = (cnt_q == CntFull);
    assign empty = (cnt_q == '0);

    // Source selection: a locked request keeps its source; otherwise a lone
    // requester wins and a tie goes to whoever was not granted last.
    always_comb begin
        sel = ~rr_last_q;
        if (locked_q) begin
            sel = lock_src_q;
        end else if (instr_req && !data_req) begin
            sel = SrcInstr;
        end else if (data_req && !instr_req) begin
            sel = SrcData;
        end
    end

    // Shared-port request mux; nothing is issued while the ID FIFO is full.
    always_comb begin
        mem_req   = !full && (locked_q || instr_req || data_req);
        mem_addr  = (sel == SrcData) ? data_addr  : instr_addr;
        mem_we    = (sel == SrcData) ? data_we    : 1'b0;
        mem_be    = (sel == SrcData) ? data_be    : 4'hF;
        mem_wdata = (sel == SrcData) ? data_wdata : 32'h0;
    end

    assign grant     = mem_req && mem_gnt;
    assign instr_gnt = grant && (sel == SrcInstr);
    assign data_gnt  = grant && (sel == SrcData);

    // Response routing from the oldest ID; a response with nothing in flight
    // is dropped here and only recorded in the sticky underflow flag.
    always_comb begin
        head_id      = id_fifo_q[rd_ptr_q];
        resp_fire    = mem_rvalid && !empty;
        instr_rvalid = resp_fire && (head_id == SrcInstr);
        data_rvalid  = resp_fire && (head_id == SrcData);
        instr_rdata  = mem_rdata;
        data_rdata   = mem_rdata;
        instr_err    = instr_rvalid && mem_err;
        data_err     = data_rvalid && mem_err;
    end

    assign outstanding    = cnt_q;
    assign resp_underflow = underflow_q;

    // Next-state for arbitration history, lock, ID FIFO and counters.
    always_comb begin
        rr_last_d   = rr_last_q;
        locked_d    = mem_req && !mem_gnt;
        lock_src_d  = sel;
        id_fifo_d   = id_fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        underflow_d = underflow_q | (mem_rvalid && empty);

        if (grant) begin
            rr_last_d           = sel;
            id_fifo_d[wr_ptr_q] = sel;
            wr_ptr_d            = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (resp_fire) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
        end

        case ({grant, resp_fire})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset empties the FIFO, drops any lock and lets instr
    // win the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last_q   <= SrcData;
            locked_q    <= 1'b0;
            lock_src_q  <= SrcInstr;
            id_fifo_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            rr_last_q   <= rr_last_d;
            locked_q    <= locked_d;
            lock_src_q  <= lock_src_d;
            id_fifo_q   <= id_fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
